// File: rtl/led7seg_scan4_pkg.sv
// Shared types, anode codes and digit helpers for the 4-digit
// seven-segment scanner.
package led7seg_scan4_pkg;

    localparam int NDIG = 4;

    localparam logic [3:0] SA_OFF  = 4'b1111;
    localparam logic [3:0] SA_DIG0 = 4'b1110;
    localparam logic [3:0] SA_DIG1 = 4'b1101;
    localparam logic [3:0] SA_DIG2 = 4'b1011;
    localparam logic [3:0] SA_DIG3 = 4'b0111;

    typedef logic [1:0] idx_t;

    typedef struct packed {
        logic [3:0]  dp;
        logic [15:0] val;
    } frame_t;

    function automatic logic [3:0] sa_code(input idx_t k);
        logic [3:0] r;
        r = SA_OFF;
        unique case (k)
            2'd0: r = SA_DIG0;
            2'd1: r = SA_DIG1;
            2'd2: r = SA_DIG2;
            2'd3: r = SA_DIG3;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] nib(
        input logic [15:0] v,
        input idx_t        k
    );
        return v[4*k +: 4];
    endfunction

    // Leading-zero test: digit k is blank when it and everything left of it is 0.
    function automatic logic zb(
        input logic [15:0] v,
        input idx_t        k,
        input logic        en
    );
        logic r;
        r = 1'b0;
        unique case (k)
            2'd0: r = 1'b0;
            2'd1: r = en && (v[15:4] == 12'h000);
            2'd2: r = en && (v[15:8] == 8'h00);
            2'd3: r = en && (v[15:12] == 4'h0);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led7seg_scan4_if.sv
// Value-load and display-drive bundle between the datapath,
// the scanner and the segment decoder.
interface led7seg_scan4_if;

    logic        load;
    logic [15:0] d;
    logic [3:0]  dpin;
    logic [3:0]  i;
    logic        dp;
    logic        blank;
    logic [3:0]  sa;
    logic        pend;

    modport master (
        output load,
        output d,
        output dpin,
        input  i,
        input  dp,
        input  blank,
        input  sa,
        input  pend
    );

    modport slave (
        input  load,
        input  d,
        input  dpin,
        output i,
        output dp,
        output blank,
        output sa,
        output pend
    );

endinterface

// File: rtl/led7seg_scan4_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last cycle.
module led7seg_scan4_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/led7seg_scan4.sv
// Time-multiplexed 4-digit scanner with frame-aligned
// double-buffered value updates.
module led7seg_scan4
    import led7seg_scan4_pkg::*;
#(
    parameter int DIV    = 50000,
    parameter bit ZBLANK = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    led7seg_scan4_if.slave bus
);

    logic   tick;
    logic   upd;
    logic   frame;
    idx_t   idx;
    frame_t shadow;
    frame_t disp;
    frame_t din;
    logic   pend;

    logic [3:0] sa_q;
    logic [3:0] i_q;
    logic       dp_q;
    logic       blank_q;

    led7seg_scan4_prescaler #(
        .DIV (DIV)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign frame    = tick && (idx == 2'd3);
    assign din.dp   = bus.dpin;
    assign din.val  = bus.d;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 2'd3;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // A load that lands on the boundary goes straight to the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            disp   <= '0;
            pend   <= 1'b0;
        end else if (frame && bus.load) begin
            shadow <= din;
            disp   <= din;
            pend   <= 1'b0;
        end else if (bus.load) begin
            shadow <= din;
            pend   <= 1'b1;
        end else if (frame && pend) begin
            disp   <= shadow;
            pend   <= 1'b0;
        end
    end

    // Anodes go dark for one cycle after each tick to avoid ghosting.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd     <= 1'b0;
            sa_q    <= SA_OFF;
            i_q     <= 4'h0;
            dp_q    <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            upd <= tick;
            if (tick) begin
                sa_q <= SA_OFF;
            end else if (upd) begin
                sa_q    <= sa_code(idx);
                i_q     <= nib(disp.val, idx);
                dp_q    <= disp.dp[idx];
                blank_q <= zb(disp.val, idx, ZBLANK);
            end
        end
    end

    assign bus.sa    = sa_q;
    assign bus.i     = i_q;
    assign bus.dp    = dp_q;
    assign bus.blank = blank_q;
    assign bus.pend  = pend;

endmodule

// File: tb/tb_led7seg_scan4.sv
// Directed table-driven bench for led7seg_scan4 with DIV=4, ZBLANK=1.
module tb_led7seg_scan4;
    import led7seg_scan4_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    led7seg_scan4_if bus ();

    led7seg_scan4 #(
        .DIV    (4),
        .ZBLANK (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dpin;
        logic [3:0]  eblank;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       name,
        input logic [15:0] act,
        input logic [15:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_sa(input logic [3:0] code);
        int n;
        n = 0;
        while (bus.sa !== code && n < 40) begin
            step();
            n++;
        end
        if (bus.sa !== code) begin
            checks++;
            errors++;
            $display("FAIL wait_sa actual %b required %b", bus.sa, code);
        end
    endtask

    task automatic pulse_load(
        input logic [15:0] d,
        input logic [3:0]  dpin
    );
        bus.load = 1'b1;
        bus.d    = d;
        bus.dpin = dpin;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.load = 1'b0;
        bus.d    = 16'h0000;
        bus.dpin = 4'h0;

        vecs[0] = '{16'h12A0, 4'b0010, 4'b0000};
        vecs[1] = '{16'h0005, 4'b0000, 4'b1110};
        vecs[2] = '{16'h0000, 4'b0000, 4'b1110};
        vecs[3] = '{16'h0F00, 4'b1001, 4'b1000};
        vecs[4] = '{16'h8000, 4'b0100, 4'b0000};

        repeat (3) step();
        chk("rst_sa", 16'(bus.sa), 16'hF);
        chk("rst_blank", 16'(bus.blank), 16'h1);
        chk("rst_pend", 16'(bus.pend), 16'h0);
        chk("rst_i", 16'(bus.i), 16'h0);
        chk("rst_dp", 16'(bus.dp), 16'h0);
        rst = 1'b0;

        for (int e = 0; e < 3; e++) begin
            step();
            chk("pre_tick_sa", 16'(bus.sa), 16'hF);
        end
        step();
        chk("edge3_sa", 16'(bus.sa), 16'hF);
        step();
        chk("edge4_sa", 16'(bus.sa), 16'(SA_DIG0));
        chk("edge4_i", 16'(bus.i), 16'h0);
        chk("edge4_blank", 16'(bus.blank), 16'h0);

        for (int n = 0; n < 5; n++) begin
            v = vecs[n];
            wait_sa(SA_DIG1);
            pulse_load(v.d, v.dpin);
            chk("pend_set", 16'(bus.pend), 16'h1);
            wait_sa(SA_DIG3);
            chk("pend_hold", 16'(bus.pend), 16'h1);
            wait_sa(SA_DIG0);
            chk("pend_clr", 16'(bus.pend), 16'h0);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) wait_sa(sa_code(idx_t'(k)));
                chk("vec_i", 16'(bus.i), 16'(v.d[4*k +: 4]));
                chk("vec_blank", 16'(bus.blank), 16'(v.eblank[k]));
                chk("vec_dp", 16'(bus.dp), 16'(v.dpin[k]));
            end
        end

        wait_sa(SA_DIG1);
        pulse_load(16'h1111, 4'h0);
        wait_sa(SA_DIG2);
        pulse_load(16'h2222, 4'h0);
        chk("dbl_pend", 16'(bus.pend), 16'h1);
        wait_sa(SA_DIG0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) wait_sa(sa_code(idx_t'(k)));
            chk("dbl_i", 16'(bus.i), 16'h2);
            chk("dbl_blank", 16'(bus.blank), 16'h0);
        end

        wait_sa(SA_DIG0);
        wait_sa(SA_DIG3);
        step();
        step();
        pulse_load(16'hBEEF, 4'h0);
        chk("col_pend", 16'(bus.pend), 16'h0);
        chk("col_dead", 16'(bus.sa), 16'hF);
        step();
        chk("col_sa", 16'(bus.sa), 16'(SA_DIG0));
        chk("col_i0", 16'(bus.i), 16'hF);
        chk("col_pend2", 16'(bus.pend), 16'h0);
        wait_sa(SA_DIG1);
        chk("col_i1", 16'(bus.i), 16'hE);

        pulse_load(16'h7777, 4'hF);
        chk("mid_pend", 16'(bus.pend), 16'h1);
        wait_sa(SA_DIG2);
        rst = 1'b1;
        step();
        chk("mid_sa", 16'(bus.sa), 16'hF);
        chk("mid_pend0", 16'(bus.pend), 16'h0);
        chk("mid_blank", 16'(bus.blank), 16'h1);
        step();
        step();
        rst = 1'b0;
        wait_sa(SA_DIG0);
        chk("post_i0", 16'(bus.i), 16'h0);
        chk("post_blank0", 16'(bus.blank), 16'h0);
        chk("post_dp0", 16'(bus.dp), 16'h0);
        wait_sa(SA_DIG1);
        chk("post_blank1", 16'(bus.blank), 16'h1);
        wait_sa(SA_DIG3);
        chk("post_pend", 16'(bus.pend), 16'h0);
        wait_sa(SA_DIG0);
        chk("post_i0b", 16'(bus.i), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
